// File: rtl/avalon_arbiter_pkg.sv
// avalon_arbiter_pkg
//   Shared types for the two-master Avalon-MM arbiter: bus widths, the
//   arbiter FSM state enum and the 1-bit master index.
//   No ports (package).
package avalon_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  // 0 = master 0 (instruction port), 1 = master 1 (data port)
  typedef logic master_idx_t;

  // GRANT state that belongs to a given master index.
  function automatic arb_state_t grant_state(master_idx_t m);
    return m ? GRANT1 : GRANT0;
  endfunction

endpackage

// File: rtl/avalon_arbiter_if.sv
// avalon_arbiter_if
//   One Avalon-MM link (address, byte lanes, read/write strobes, data,
//   waitrequest, readdata).
//   Modports:
//     master : the side that issues transfers (drives address/read/write...)
//     slave  : the side that answers (drives waitrequest/readdata)
interface avalon_arbiter_if;
  import avalon_arbiter_pkg::*;

  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata
  );

endinterface

// File: rtl/avalon_rr_select.sv
// avalon_rr_select
//   Two-way round-robin pick used when the arbiter is idle.
//   Ports:
//     req[1:0]   : request vector, bit n = master n requesting
//     last_grant : master that received the most recent grant
//     winner     : master to grant next (don't-care when req == 0)
module avalon_rr_select
  import avalon_arbiter_pkg::*;
(
  input  logic [1:0]  req,
  input  master_idx_t last_grant,
  output master_idx_t winner
);

  always_comb begin
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      // Contention: whoever did not win last time goes next.
      2'b11:   winner = ~last_grant;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/avalon_arbiter.sv
// avalon_arbiter
//   Arbitrates two Avalon-MM masters onto one shared RAM slave.
//   A grant is decided in IDLE and held until the granted master completes
//   (request with s_waitrequest low) or drops its request; the FSM then
//   returns to IDLE for one cycle before the next grant.
//   Parameters:
//     FIRST_PRIORITY : master that wins the first contended request after reset
//   Ports:
//     clk   : clock, all state on its rising edge
//     reset : asynchronous, active-high
//     m0    : master 0 (instruction port), arbiter is its slave
//     m1    : master 1 (data port), arbiter is its slave
//     s     : link to the shared RAM, arbiter is its master
module avalon_arbiter
  import avalon_arbiter_pkg::*;
#(
  parameter int FIRST_PRIORITY = 0
) (
  input  logic            clk,
  input  logic            reset,
  avalon_arbiter_if.slave  m0,
  avalon_arbiter_if.slave  m1,
  avalon_arbiter_if.master s
);

  // Reset value of last_grant is the *other* master, so FIRST_PRIORITY wins
  // the first contended arbitration.
  localparam master_idx_t LAST_GRANT_RST = (FIRST_PRIORITY == 0) ? 1'b1 : 1'b0;

  arb_state_t  state_reg, state_next;
  master_idx_t last_grant_reg, last_grant_next;
  master_idx_t winner;
  logic [1:0]  req;

  assign req = {m1.read | m1.write, m0.read | m0.write};

  avalon_rr_select u_rr_select (
    .req        (req),
    .last_grant (last_grant_reg),
    .winner     (winner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= LAST_GRANT_RST;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
    end
  end

  // Read data is broadcast; only the granted master treats it as valid.
  assign m0.readdata = s.readdata;
  assign m1.readdata = s.readdata;

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    s.address       = '0;
    s.byteenable    = '0;
    s.read          = 1'b0;
    s.write         = 1'b0;
    s.writedata     = '0;
    m0.waitrequest  = 1'b1;
    m1.waitrequest  = 1'b1;

    case (state_reg)
      IDLE: begin
        if (|req) begin
          state_next      = grant_state(winner);
          last_grant_next = winner;
        end
      end

      GRANT0: begin
        s.address      = m0.address;
        s.byteenable   = m0.byteenable;
        s.read         = m0.read;
        s.write        = m0.write;
        s.writedata    = m0.writedata;
        m0.waitrequest = s.waitrequest;
        // Completion or abandoned request both release the slave.
        if (!req[0] || !s.waitrequest) begin
          state_next = IDLE;
        end
      end

      GRANT1: begin
        s.address      = m1.address;
        s.byteenable   = m1.byteenable;
        s.read         = m1.read;
        s.write        = m1.write;
        s.writedata    = m1.writedata;
        m1.waitrequest = s.waitrequest;
        if (!req[1] || !s.waitrequest) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_avalon_arbiter.sv
// tb_avalon_arbiter
//   Self-checking bench for avalon_arbiter. Two master drivers issue
//   transactions from stimulus queues and push the expected slave-side
//   transfer into per-master scoreboard queues. A monitor on the slave link
//   pops and compares on every completion. Grant choice is predicted from the
//   arbitration rules: the masters with an outstanding request in the idle
//   cycle before a transfer starts are candidates; a sole candidate wins,
//   two candidates -> the one that did not win last time.
module tb_avalon_arbiter;
  import avalon_arbiter_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gap;
    int          abort_after;
  } txn_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  avalon_arbiter_if m0_if ();
  avalon_arbiter_if m1_if ();
  avalon_arbiter_if s_if ();

  avalon_arbiter #(.FIRST_PRIORITY(0)) dut (
    .clk   (clk),
    .reset (reset),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if)
  );

  int checks = 0;
  int errors = 0;

  txn_t stim_q0[$], stim_q1[$];
  txn_t exp_q0[$], exp_q1[$];
  int   grant_log[$];
  int   len_log[$];
  bit   busy0 = 1'b0, busy1 = 1'b0;

  // Slave model: data is a fixed function of the address.
  function automatic logic [31:0] slave_data(logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign s_if.readdata = slave_data(s_if.address);

  int wait_pct = 0;
  int hold_cnt = 0;

  initial begin
    s_if.waitrequest = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold_cnt > 0 && (s_if.read || s_if.write)) begin
        s_if.waitrequest = 1'b1;
        hold_cnt--;
      end else begin
        s_if.waitrequest = ($urandom_range(99) < wait_pct);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- master drivers ----------------
  task automatic drive(input int n, input txn_t t);
    if (n == 0) begin
      m0_if.address = t.addr; m0_if.byteenable = t.be; m0_if.read = t.rd;
      m0_if.write = t.wr; m0_if.writedata = t.wdata;
    end else begin
      m1_if.address = t.addr; m1_if.byteenable = t.be; m1_if.read = t.rd;
      m1_if.write = t.wr; m1_if.writedata = t.wdata;
    end
  endtask

  task automatic idle_master(input int n);
    txn_t t;
    t.addr = '0; t.be = '0; t.rd = 1'b0; t.wr = 1'b0; t.wdata = '0;
    t.rdata = '0; t.gap = 0; t.abort_after = 0;
    drive(n, t);
  endtask

  task automatic run_master(input int n);
    txn_t t;
    int   k;
    idle_master(n);
    @(posedge clk);
    #1;
    forever begin
      if ((n == 0 ? stim_q0.size() : stim_q1.size()) == 0) begin
        idle_master(n);
        if (n == 0) busy0 = 1'b0; else busy1 = 1'b0;
        @(posedge clk);
        #1;
        continue;
      end
      if (n == 0) begin busy0 = 1'b1; t = stim_q0.pop_front(); end
      else begin busy1 = 1'b1; t = stim_q1.pop_front(); end
      if (t.gap > 0) begin
        idle_master(n);
        repeat (t.gap) @(posedge clk);
        #1;
      end
      t.rdata = slave_data(t.addr);
      drive(n, t);
      if (t.abort_after == 0) begin
        if (n == 0) exp_q0.push_back(t); else exp_q1.push_back(t);
      end
      k = 0;
      forever begin
        @(negedge clk);
        k++;
        if (t.abort_after > 0) begin
          if (k >= t.abort_after) break;
        end else begin
          if ((n == 0 ? m0_if.waitrequest : m1_if.waitrequest) == 1'b0) break;
          if (k > 400) begin
            checks++;
            errors++;
            $display("FAIL m%0d_timeout: no completion after %0d cycles", n, k);
            break;
          end
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial run_master(0);
  initial run_master(1);

  // ---------------- monitor / scoreboard ----------------
  bit         mon_en = 1'b0;
  logic       mon_prev_active, mon_prev_done;
  logic [1:0] mon_cand;
  int         mon_last, mon_owner, mon_len;
  txn_t       mon_f;
  logic       mon_act, mon_have;

  task automatic mon_reset();
    mon_prev_active = 1'b0;
    mon_prev_done   = 1'b0;
    mon_cand        = 2'b00;
    mon_last        = 1;   // FIRST_PRIORITY = 0 -> last_grant resets to 1
    mon_owner       = 0;
    mon_len         = 0;
  endtask

  initial begin
    mon_reset();
    forever begin
      @(negedge clk);
      if (!mon_en || reset) continue;
      mon_act = s_if.read | s_if.write;
      if (mon_act) begin
        if (!mon_prev_active || mon_prev_done) begin
          chk("bubble_after_completion", {31'b0, mon_prev_done}, 32'd0);
          case (mon_cand)
            2'b01: mon_owner = 0;
            2'b10: mon_owner = 1;
            2'b11: mon_owner = (mon_last == 0) ? 1 : 0;
            default: begin
              checks++;
              errors++;
              $display("FAIL spurious_grant: slave active, got no pending request, expected idle");
              mon_owner = 0;
            end
          endcase
          mon_last = mon_owner;
          grant_log.push_back(mon_owner);
          mon_len = 0;
        end
        mon_len++;
        mon_have = (mon_owner == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
        if (!mon_have) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: got transfer for m%0d, expected none", mon_owner);
        end else begin
          mon_f = (mon_owner == 0) ? exp_q0[0] : exp_q1[0];
          chk("s_address", s_if.address, mon_f.addr);
          chk("s_byteenable", {28'b0, s_if.byteenable}, {28'b0, mon_f.be});
          chk("s_read_write", {30'b0, s_if.read, s_if.write}, {30'b0, mon_f.rd, mon_f.wr});
          chk("s_writedata", s_if.writedata, mon_f.wdata);
          if (mon_owner == 0) begin
            chk("granted_waitreq", {31'b0, m0_if.waitrequest}, {31'b0, s_if.waitrequest});
            chk("other_waitreq", {31'b0, m1_if.waitrequest}, 32'd1);
          end else begin
            chk("granted_waitreq", {31'b0, m1_if.waitrequest}, {31'b0, s_if.waitrequest});
            chk("other_waitreq", {31'b0, m0_if.waitrequest}, 32'd1);
          end
          if (!s_if.waitrequest) begin
            if (mon_f.rd) begin
              chk("m0_readdata", m0_if.readdata, mon_f.rdata);
              chk("m1_readdata", m1_if.readdata, mon_f.rdata);
            end
            if (mon_owner == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
            len_log.push_back(mon_len);
          end
        end
        mon_prev_done = !s_if.waitrequest;
      end else begin
        chk("idle_s_ctrl", {26'b0, s_if.read, s_if.write, s_if.byteenable}, 32'd0);
        chk("idle_s_address", s_if.address, 32'd0);
        chk("idle_s_writedata", s_if.writedata, 32'd0);
        chk("idle_waitreqs", {30'b0, m1_if.waitrequest, m0_if.waitrequest}, 32'd3);
        if (!mon_prev_active) chk("arb_latency_pending", {30'b0, mon_cand}, 32'd0);
        mon_prev_done = 1'b0;
      end
      mon_prev_active = mon_act;
      mon_cand = {exp_q1.size() != 0, exp_q0.size() != 0};
    end
  end

  // ---------------- stimulus ----------------
  function automatic txn_t mk(input logic [31:0] a, input logic [3:0] be, input logic rd,
                              input logic wr, input logic [31:0] wd, input int gap);
    txn_t t;
    t.addr = a; t.be = be; t.rd = rd; t.wr = wr; t.wdata = wd;
    t.rdata = '0; t.gap = gap; t.abort_after = 0;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    int kind;
    kind = $urandom_range(9);
    return mk($urandom & 32'hFFFF_FFFC, 4'($urandom_range(1, 15)),
              (kind == 0) || (kind < 5), (kind == 0) || (kind >= 5),
              $urandom, $urandom_range(0, 3));
  endfunction

  task automatic wait_all_idle();
    for (int k = 0; k < 20000; k++) begin
      @(posedge clk);
      #2;
      if (stim_q0.size() == 0 && stim_q1.size() == 0 && !busy0 && !busy1) return;
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: got masters still busy, expected idle");
  endtask

  txn_t abort_t;

  initial begin
    #3;
    chk("rst_s_read_write", {30'b0, s_if.read, s_if.write}, 32'd0);
    chk("rst_waitreqs", {30'b0, m1_if.waitrequest, m0_if.waitrequest}, 32'd3);
    chk("rst_s_address", s_if.address, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mon_reset();
    mon_en = 1'b1;

    // Simultaneous continuous requests after reset: m0 first, then alternate.
    grant_log.delete();
    for (int i = 0; i < 3; i++) begin
      stim_q0.push_back(mk(32'h100 + 32'(i * 4), 4'hF, 1'b1, 1'b0, 32'h0, 0));
      stim_q1.push_back(mk(32'h200 + 32'(i * 4), 4'hF, 1'b0, 1'b1, 32'hA000 + 32'(i), 0));
    end
    wait_all_idle();
    chk("alternation_count", grant_log.size(), 32'd6);
    for (int i = 0; i < grant_log.size() && i < 6; i++)
      chk("alternation_order", grant_log[i], i % 2);
    $display("phase contention: %0d grants", grant_log.size());

    // Lone m0 read, no slave stall.
    grant_log.delete();
    len_log.delete();
    stim_q0.push_back(mk(32'h0000_0010, 4'hF, 1'b1, 1'b0, 32'h0, 0));
    wait_all_idle();
    chk("single_read_grants", grant_log.size(), 32'd1);
    if (grant_log.size() == 1) chk("single_read_owner", grant_log[0], 32'd0);
    if (len_log.size() == 1) chk("single_read_len", len_log[0], 32'd1);
    $display("phase single read: %0d grants", grant_log.size());

    // m1 write held off by 3 stall cycles while m0 starts asking.
    grant_log.delete();
    len_log.delete();
    hold_cnt = 3;
    stim_q1.push_back(mk(32'h0000_0400, 4'b0011, 1'b0, 1'b1, 32'hDEAD_BEEF, 0));
    stim_q0.push_back(mk(32'h0000_0020, 4'hF, 1'b1, 1'b0, 32'h0, 1));
    wait_all_idle();
    chk("stall_grants", grant_log.size(), 32'd2);
    if (grant_log.size() == 2) begin
      chk("stall_first_owner", grant_log[0], 32'd1);
      chk("stall_second_owner", grant_log[1], 32'd0);
    end
    if (len_log.size() >= 1) chk("stall_len", len_log[0], 32'd4);
    $display("phase stall: %0d grants", grant_log.size());

    // Random traffic with random slave stalls.
    grant_log.delete();
    wait_pct = 35;
    for (int i = 0; i < 150; i++) begin
      stim_q0.push_back(rand_txn());
      stim_q1.push_back(rand_txn());
    end
    wait_all_idle();
    wait_pct = 0;
    chk("random_grant_count", grant_log.size(), 32'd300);
    $display("phase random: %0d grants", grant_log.size());

    // Reset in the middle of a GRANT1 write.
    mon_en = 1'b0;
    hold_cnt = 1000;
    abort_t = mk(32'h0000_0400, 4'hF, 1'b0, 1'b1, 32'hCAFE_F00D, 0);
    abort_t.abort_after = 8;
    stim_q1.push_back(abort_t);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (s_if.write) break;
    end
    chk("grant1_reached", {31'b0, s_if.write}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_s_write", {31'b0, s_if.write}, 32'd0);
    chk("rst_mid_waitreqs", {30'b0, m1_if.waitrequest, m0_if.waitrequest}, 32'd3);
    chk("rst_mid_s_address", s_if.address, 32'd0);
    hold_cnt = 0;
    wait_all_idle();
    @(posedge clk);
    #1;
    reset = 1'b0;
    mon_reset();
    mon_en = 1'b1;
    grant_log.delete();
    stim_q0.push_back(mk(32'h0000_0030, 4'hF, 1'b1, 1'b0, 32'h0, 0));
    stim_q1.push_back(mk(32'h0000_0034, 4'hF, 1'b1, 1'b0, 32'h0, 0));
    wait_all_idle();
    chk("post_reset_grants", grant_log.size(), 32'd2);
    if (grant_log.size() == 2) begin
      chk("post_reset_first", grant_log[0], 32'd0);
      chk("post_reset_second", grant_log[1], 32'd1);
    end
    $display("phase reset: %0d grants", grant_log.size());

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/avalon_arbiter.md
AVALON_ARBITER -- requirements
Module: avalon_arbiter

Interface
REQ-001 SHALL have parameter FIRST_PRIORITY, default 0, naming the master that wins the first simultaneous request after reset.
REQ-002 clk  input  1  single clock; all state on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 m0_address  input  32  master 0 (instruction port) byte address.
REQ-005 m0_byteenable  input  4  master 0 byte lanes.
REQ-006 m0_read  input  1  master 0 read request.
REQ-007 m0_write  input  1  master 0 write request.
REQ-008 m0_writedata  input  32  master 0 write data.
REQ-009 m0_waitrequest  output  1  stall to master 0.
REQ-010 m0_readdata  output  32  read data to master 0.
REQ-011 m1_address, m1_byteenable, m1_read, m1_write, m1_writedata, m1_waitrequest, m1_readdata SHALL mirror REQ-004..010 for master 1 (data port).
REQ-012 s_address  output  32  address to the shared RAM slave.
REQ-013 s_byteenable  output  4  byte lanes to the slave.
REQ-014 s_read  output  1  read to the slave.
REQ-015 s_write  output  1  write to the slave.
REQ-016 s_writedata  output  32  write data to the slave.
REQ-017 s_waitrequest  input  1  slave stall.
REQ-018 s_readdata  input  32  slave read data.

Function
REQ-019 Master n "requests" when mn_read|mn_write; a transfer completes in the cycle where the granted master requests and s_waitrequest=0.
REQ-020 FSM states IDLE, GRANT0, GRANT1; state is registered.
REQ-021 IDLE: one requester -> its GRANT state at next edge; both -> master other than last_grant; none -> stay IDLE.
REQ-022 last_grant register updates on every entry to a GRANT state; reset value = !FIRST_PRIORITY, so FIRST_PRIORITY wins first.
REQ-023 GRANTn: slave outputs combinationally equal master n inputs; mn_waitrequest = s_waitrequest.
REQ-024 GRANTn: on completion, or if master n drops its request, go to IDLE at next edge (one-cycle bubble between transfers, no back-to-back grant).
REQ-025 Non-granted master, and both masters in IDLE, SHALL see waitrequest=1.
REQ-026 IDLE: s_address, s_byteenable, s_writedata = 0; s_read = s_write = 0.
REQ-027 m0_readdata and m1_readdata SHALL both equal s_readdata; valid only to the granted master on a read completion.
REQ-028 Simultaneous read and write from a master SHALL be forwarded unchanged; no checking.
REQ-029 Grant never changes while s_waitrequest=1 and granted master still requests; arbitration latency from IDLE is exactly 1 cycle.

Reset
REQ-030 reset asserted asynchronously forces IDLE, last_grant = !FIRST_PRIORITY, s_read = s_write = 0, m0/m1_waitrequest = 1, including mid-transfer; the aborted transfer is not retried.

Structure
REQ-031 Package avalon_arbiter_pkg holds the state enum (IDLE, GRANT0, GRANT1) and the 1-bit master-index typedef.
REQ-032 Round-robin pick SHALL be a sub-module avalon_rr_select (inputs req[1:0], last_grant; output winner); everything else in avalon_arbiter.

Verification
REQ-033 Only m0 reads 0x00000010, slave waitrequest 0 -> s_read high cycle 1 after request, m0_readdata = slave data, FSM back in IDLE one cycle later.
REQ-034 m0 and m1 request in the same IDLE cycle after reset, FIRST_PRIORITY=0 -> m0 granted first, m1_waitrequest=1 throughout, m1 granted at the cycle after m0 completes +1.
REQ-035 Both masters request continuously for 6 transfers -> grants alternate 0,1,0,1,0,1.
REQ-036 Slave holds waitrequest for 3 cycles during m1 write of 0xDEADBEEF to 0x00000400, byteenable 4'b0011 -> s_* stable for all 4 cycles, m0 not granted.
REQ-037 reset asserted mid-GRANT1 between clock edges -> s_write=0 and both waitrequests=1 immediately; after release, first simultaneous request goes to FIRST_PRIORITY.
